alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares the single-cycle `ALU` (i_SrcA, i_SrcB, i_ALUCtrl → o_ALUResult, o_Zero) among NUM_REQ requesters.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- A 3-state FSM grants one request at a time, registers its operands, executes, and holds the registered result until the owner accepts it.
- Sits between the core's execution-side units (branch comparator, address generator, debug unit) and the single shared ALU instance.

## Interface

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..4.
- ID_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_ReqValid  in  NUM_REQ  per-requester request valid.
- o_ReqReady  out  NUM_REQ  one-hot request accept; high in the grant cycle only.
- i_ReqCtrl  in  NUM_REQ×3  per-requester ALU opcode.
- i_ReqA, i_ReqB  in  NUM_REQ×32  per-requester operands.
- o_RspValid  out  NUM_REQ  one-hot response valid, to the owner only.
- i_RspReady  in  NUM_REQ  per-requester response accept.
- o_RspResult  out  32  registered ALU result, shared by all requesters.
- o_RspZero  out  1  registered ALU zero flag.
- o_Busy  out  1  high whenever the state is not IDLE.

## Operation

- States: IDLE, EXEC, RESP. Reset value: IDLE.
- IDLE:
  - If any i_ReqValid is high, select grant g per the policy (see Configuration).
  - Drive o_ReqReady[g]=1 combinationally.
  - Latch i_ReqCtrl[g], i_ReqA[g], i_ReqB[g] and g into the operand registers, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The ALU is fed only from the operand registers.
  - Capture o_ALUResult and o_Zero into the result registers, then go to RESP.
- RESP:
  - Drive o_RspValid[g]=1.
  - On i_RspReady[g]=1, go to IDLE and update the round-robin pointer.
  - Otherwise hold the state; result and zero flag stay stable.
- Opcodes are passed through unchecked. Undefined codes produce whatever the ALU's default branch produces.
- Requesters hold valid and operands stable until ready. A valid that drops before ready is legal and no grant occurs; the bench does not check it.
- Readiness of non-owners is ignored. No new request is accepted until RESP completes.
- Reset values: state IDLE, pointer 0, operand and result registers 0; o_ReqReady, o_RspValid, o_RspResult, o_RspZero and o_Busy are all 0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and the pointer returns to 0.

## Timing

- Request accepted at edge T (ready high during cycle T-1→T); EXEC in the following cycle; o_RspValid high from cycle T+1→T+2 onward.
- Latency is 2 cycles from accept to response valid.
- Maximum throughput is one operation per 3 cycles when i_RspReady is held high.
- Response handshake completes at edge R. The earliest next accept is edge R+1.
- o_ReqReady is combinational from state, pointer and i_ReqValid. There is no combinational path from i_RspReady to o_ReqReady.
- All other outputs are registered or decoded directly from state.

## Configuration

- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - After each completed response, pointer = (g+1) mod NUM_REQ.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented.

## Structure

- Package `alu_arb_pkg` holds:
  - the ALUOp enum (ADD=000, SUB=001, AND=010, OR=011, SLT=101);
  - the FSM state enum;
  - localparam MAX_REQ=4.
- Sub-module `rr_arbiter`: a combinational grant picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Contains both policies, selected by ALU_ARB_RR_EN.
- The existing `ALU` is instantiated once inside alu_arbiter.

## Test plan

- Reset behaviour: assert i_RST for 2 cycles, then release → all outputs 0, o_Busy=0.
- Single request:
  - Stimulus: req0 ADD FFFFFFFF+00000001, i_RspReady high.
  - Required: ready0 in the accept cycle; 2 cycles later RspValid[0]=1, result 00000000, Zero=1.
- Contention, both requesters valid every cycle (req0 SUB FF−0F, req1 OR FF00|00FF):
  - Round-robin build: grants alternate 0,1,0 with results 000000F0 and 0000FFFF.
  - Fixed-priority build: req0 is granted repeatedly.
- Response back-pressure:
  - Stimulus: req1 SLT 00000001 vs 80000000 with i_RspReady[1] low for 5 cycles.
  - Required: RspValid[1] stays high, result 00000000 stays stable, and req0 is not accepted during the hold.
- Reset mid-operation:
  - Stimulus: req0 AND 0000000F&0000000A accepted, then i_RST asserted in the EXEC cycle.
  - Required: no RspValid appears and state is IDLE.
  - Required: a subsequent req1 alone is granted and returns its result.
- Pointer wrap (NUM_REQ=3, round-robin):
  - Stimulus: only req2 valid, then all three valid.
  - Required: after req2 completes, the next grant is req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: opcode and FSM state enums, request bundle.
package alu_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int DATA_W  = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared ALU arbiter.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       i_ReqValid;
    logic [NUM_REQ-1:0]       o_ReqReady;
    logic [NUM_REQ-1:0][2:0]  i_ReqCtrl;
    logic [NUM_REQ-1:0][31:0] i_ReqA;
    logic [NUM_REQ-1:0][31:0] i_ReqB;
    logic [NUM_REQ-1:0]       o_RspValid;
    logic [NUM_REQ-1:0]       i_RspReady;
    logic [31:0]              o_RspResult;
    logic                     o_RspZero;
    logic                     o_Busy;

    modport master (
        output i_ReqValid, i_ReqCtrl, i_ReqA, i_ReqB, i_RspReady,
        input  o_ReqReady, o_RspValid, o_RspResult, o_RspZero, o_Busy
    );

    modport slave (
        input  i_ReqValid, i_ReqCtrl, i_ReqA, i_ReqB, i_RspReady,
        output o_ReqReady, o_RspValid, o_RspResult, o_RspZero, o_Busy
    );
endinterface

// File: rtl/ALU.sv
// Single-cycle 32-bit ALU shared by the arbiter's requesters.
module ALU
    import alu_arb_pkg::*;
(
    input  logic [31:0] i_SrcA,
    input  logic [31:0] i_SrcB,
    input  logic [2:0]  i_ALUCtrl,
    output logic [31:0] o_ALUResult,
    output logic        o_Zero
);

    always_comb begin
        o_ALUResult = '0;
        case (i_ALUCtrl)
            ALU_ADD: o_ALUResult = i_SrcA + i_SrcB;
            ALU_SUB: o_ALUResult = i_SrcA - i_SrcB;
            ALU_AND: o_ALUResult = i_SrcA & i_SrcB;
            ALU_OR:  o_ALUResult = i_SrcA | i_SrcB;
            // Signed compare, as used by the branch comparator.
            ALU_SLT: o_ALUResult = {31'b0, $signed(i_SrcA) < $signed(i_SrcB)};
            default: o_ALUResult = '0;
        endcase
    end

    assign o_Zero = (o_ALUResult == 32'd0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational grant picker. ALU_ARB_RR_EN selects round-robin from ptr;
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

`ifdef ALU_ARB_RR_EN
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] slot;

    // Visit requesters ptr, ptr+1, ... wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        slot        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            slot = sum[ID_W-1:0];
            if (!grant_valid && req[slot]) begin
                grant[slot] = 1'b1;
                grant_idx   = slot;
                grant_valid = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Scanning downward lets the lowest requesting index overwrite the rest.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant       = '0;
                grant[k]    = 1'b1;
                grant_idx   = ID_W'(k);
                grant_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters: IDLE -> EXEC -> RESP per operation.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    alu_arbiter_if.slave  bus
);

    state_e              state_reg, state_next;
    alu_req_t            op_reg;
    logic [ID_W-1:0]     owner_reg;
    logic [31:0]         result_reg;
    logic                zero_reg;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;
    logic [ID_W-1:0]     arb_ptr;
    logic                accept;
    logic                rsp_fire;
    logic [31:0]         alu_result;
    logic                alu_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req         (bus.i_ReqValid),
        .ptr         (arb_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    ALU u_alu (
        .i_SrcA      (op_reg.a),
        .i_SrcB      (op_reg.b),
        .i_ALUCtrl   (op_reg.ctrl),
        .o_ALUResult (alu_result),
        .o_Zero      (alu_zero)
    );

    assign accept   = (state_reg == ST_IDLE) && grant_valid;
    assign rsp_fire = (state_reg == ST_RESP) && bus.i_RspReady[owner_reg];

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] ptr_reg;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ptr_reg <= '0;
        end else if (rsp_fire) begin
            ptr_reg <= (owner_reg == ID_W'(NUM_REQ - 1)) ? '0 : owner_reg + ID_W'(1);
        end
    end

    assign arb_ptr = ptr_reg;
`else
    assign arb_ptr = '0;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_fire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Ready depends only on state, pointer and request valids, never on i_RspReady.
    always_comb begin
        bus.o_ReqReady = '0;
        bus.o_Busy     = (state_reg != ST_IDLE);
        if (state_reg == ST_IDLE) begin
            bus.o_ReqReady = grant;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
            assign bus.o_RspValid[gi] = (state_reg == ST_RESP) && (owner_reg == ID_W'(gi));
        end
    endgenerate

    // The ALU sees only registered operands, so requesters may change inputs after accept.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            op_reg     <= '0;
            owner_reg  <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg.ctrl <= bus.i_ReqCtrl[grant_idx];
                op_reg.a    <= bus.i_ReqA[grant_idx];
                op_reg.b    <= bus.i_ReqB[grant_idx];
                owner_reg   <= grant_idx;
            end
            if (state_reg == ST_EXEC) begin
                result_reg <= alu_result;
                zero_reg   <= alu_zero;
            end
        end
    end

    assign bus.o_RspResult = result_reg;
    assign bus.o_RspZero   = zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (2- and 3-requester instances).
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(2)) bus2();
    alu_arbiter_if #(.NUM_REQ(3)) bus3();

    alu_arbiter #(.NUM_REQ(2)) dut2 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus2.slave)
    );

    alu_arbiter #(.NUM_REQ(3)) dut3 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_g2;
    logic [2:0] exp_g3;

    initial begin
        bus2.i_ReqValid = '0; bus2.i_ReqCtrl = '0; bus2.i_ReqA = '0;
        bus2.i_ReqB = '0;     bus2.i_RspReady = '0;
        bus3.i_ReqValid = '0; bus3.i_ReqCtrl = '0; bus3.i_ReqA = '0;
        bus3.i_ReqB = '0;     bus3.i_RspReady = '0;

        // Reset state
        do_reset();
        check("rst_req_ready", 32'(bus2.o_ReqReady), 32'h0);
        check("rst_rsp_valid", 32'(bus2.o_RspValid), 32'h0);
        check("rst_result",    bus2.o_RspResult,     32'h0);
        check("rst_zero",      32'(bus2.o_RspZero),  32'h0);
        check("rst_busy",      32'(bus2.o_Busy),     32'h0);
        $display("txn reset: outputs idle");

        // Single request: ADD wraps to zero
        bus2.i_RspReady = 2'b11;
        bus2.i_ReqValid = 2'b01;
        bus2.i_ReqCtrl[0] = ALU_ADD;
        bus2.i_ReqA[0] = 32'hFFFF_FFFF;
        bus2.i_ReqB[0] = 32'h0000_0001;
        settle();
        check("single_ready", 32'(bus2.o_ReqReady), 32'h1);
        tick();
        bus2.i_ReqValid = 2'b00;
        check("single_busy_exec", 32'(bus2.o_Busy), 32'h1);
        check("single_no_rsp_exec", 32'(bus2.o_RspValid), 32'h0);
        tick();
        check("single_rsp_valid", 32'(bus2.o_RspValid), 32'h1);
        check("single_result", bus2.o_RspResult, 32'h0);
        check("single_zero", 32'(bus2.o_RspZero), 32'h1);
        tick();
        check("single_done_valid", 32'(bus2.o_RspValid), 32'h0);
        check("single_done_busy", 32'(bus2.o_Busy), 32'h0);
        $display("txn single: req0 ADD result=%08h zero=%0b", bus2.o_RspResult, bus2.o_RspZero);

        // Contention: both valid every cycle
        do_reset();
        bus2.i_RspReady = 2'b11;
        bus2.i_ReqValid = 2'b11;
        bus2.i_ReqCtrl[0] = ALU_SUB; bus2.i_ReqA[0] = 32'hFF;   bus2.i_ReqB[0] = 32'h0F;
        bus2.i_ReqCtrl[1] = ALU_OR;  bus2.i_ReqA[1] = 32'hFF00; bus2.i_ReqB[1] = 32'h00FF;
        for (int i = 0; i < 3; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_g2 = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g2 = 2'b01;
`endif
            settle();
            check("cont_grant", 32'(bus2.o_ReqReady), 32'(exp_g2));
            tick();
            tick();
            check("cont_rsp_valid", 32'(bus2.o_RspValid), 32'(exp_g2));
            check("cont_result", bus2.o_RspResult,
                  (exp_g2 == 2'b01) ? 32'h0000_00F0 : 32'h0000_FFFF);
            $display("txn contention %0d: grant=%b result=%08h", i, bus2.o_RspValid, bus2.o_RspResult);
            tick();
        end
        bus2.i_ReqValid = 2'b00;
        tick();

        // Response back-pressure on req1
        do_reset();
        bus2.i_RspReady = 2'b00;
        bus2.i_ReqValid = 2'b10;
        bus2.i_ReqCtrl[1] = ALU_SLT; bus2.i_ReqA[1] = 32'h0000_0001; bus2.i_ReqB[1] = 32'h8000_0000;
        settle();
        check("bp_grant", 32'(bus2.o_ReqReady), 32'h2);
        tick();
        bus2.i_ReqValid = 2'b01;
        bus2.i_ReqCtrl[0] = ALU_ADD; bus2.i_ReqA[0] = 32'h3; bus2.i_ReqB[0] = 32'h4;
        bus2.i_RspReady = 2'b01;
        settle();
        check("bp_exec_no_ready", 32'(bus2.o_ReqReady), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",  32'(bus2.o_RspValid), 32'h2);
            check("bp_hold_result", bus2.o_RspResult, 32'h0);
            check("bp_hold_zero",   32'(bus2.o_RspZero), 32'h1);
            check("bp_hold_noacc",  32'(bus2.o_ReqReady), 32'h0);
            tick();
        end
        bus2.i_RspReady = 2'b10;
        settle();
        check("bp_release_noacc", 32'(bus2.o_ReqReady), 32'h0);
        tick();
        settle();
        check("bp_next_grant", 32'(bus2.o_ReqReady), 32'h1);
        bus2.i_ReqValid = 2'b00;
        $display("txn backpressure: req1 SLT held 5 cycles result=%08h", bus2.o_RspResult);
        tick();

        // Reset in the EXEC cycle drops the transaction
        do_reset();
        bus2.i_RspReady = 2'b11;
        bus2.i_ReqValid = 2'b01;
        bus2.i_ReqCtrl[0] = ALU_AND; bus2.i_ReqA[0] = 32'h0F; bus2.i_ReqB[0] = 32'h0A;
        settle();
        check("mid_grant", 32'(bus2.o_ReqReady), 32'h1);
        tick();
        bus2.i_ReqValid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 32'(bus2.o_Busy), 32'h0);
        check("mid_no_rsp", 32'(bus2.o_RspValid), 32'h0);
        check("mid_result", bus2.o_RspResult, 32'h0);
        tick();
        check("mid_no_rsp_later", 32'(bus2.o_RspValid), 32'h0);
        bus2.i_ReqValid = 2'b10;
        bus2.i_ReqCtrl[1] = ALU_ADD; bus2.i_ReqA[1] = 32'h5; bus2.i_ReqB[1] = 32'h7;
        settle();
        check("mid_req1_grant", 32'(bus2.o_ReqReady), 32'h2);
        tick();
        bus2.i_ReqValid = 2'b00;
        tick();
        check("mid_req1_valid", 32'(bus2.o_RspValid), 32'h2);
        check("mid_req1_result", bus2.o_RspResult, 32'h0000_000C);
        check("mid_req1_zero", 32'(bus2.o_RspZero), 32'h0);
        $display("txn midreset: req1 ADD result=%08h", bus2.o_RspResult);
        tick();

        // Pointer wrap on the 3-requester instance
        do_reset();
        bus3.i_RspReady = 3'b111;
        bus3.i_ReqValid = 3'b100;
        bus3.i_ReqCtrl[2] = ALU_ADD; bus3.i_ReqA[2] = 32'h1;  bus3.i_ReqB[2] = 32'h2;
        bus3.i_ReqCtrl[0] = ALU_SUB; bus3.i_ReqA[0] = 32'h5;  bus3.i_ReqB[0] = 32'h5;
        bus3.i_ReqCtrl[1] = ALU_OR;  bus3.i_ReqA[1] = 32'h30; bus3.i_ReqB[1] = 32'h03;
        settle();
        check("wrap_grant2", 32'(bus3.o_ReqReady), 32'h4);
        tick();
        bus3.i_ReqValid = 3'b111;
        tick();
        check("wrap_rsp2", 32'(bus3.o_RspValid), 32'h4);
        check("wrap_result2", bus3.o_RspResult, 32'h3);
        $display("txn wrap: req2 ADD result=%08h", bus3.o_RspResult);
        tick();
        settle();
        check("wrap_grant0", 32'(bus3.o_ReqReady), 32'h1);
        tick();
        tick();
        check("wrap_rsp0", 32'(bus3.o_RspValid), 32'h1);
        check("wrap_result0", bus3.o_RspResult, 32'h0);
        check("wrap_zero0", 32'(bus3.o_RspZero), 32'h1);
        $display("txn wrap: req0 SUB result=%08h", bus3.o_RspResult);
        tick();
`ifdef ALU_ARB_RR_EN
        exp_g3 = 3'b010;
`else
        exp_g3 = 3'b001;
`endif
        settle();
        check("wrap_grant_next", 32'(bus3.o_ReqReady), 32'(exp_g3));
        bus3.i_ReqValid = 3'b000;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
